// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the serial add/subtract datapaths.
// Holds the default operand width and the serial subtractor FSM state type.
package arith_pkg;

    localparam int unsigned ARITH_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor: d = x - y - bi, bo set when the bit needs a borrow.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic w_xy;

    assign w_xy = x ^ y;
    assign d    = w_xy ^ bi;
    assign bo   = (~x & y) | (~w_xy & bi);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands arrive and results leave via valid/ready handshakes.
module serial_subtractor_16bit
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_t       r_state;
    sub_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bo;

    // The single arithmetic cell, fed by the operand LSBs and the borrow flop.
    full_subtractor u_fs (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .bi (r_br),
        .d  (w_d),
        .bo (w_bo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == LAST_BIT) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operands and result shift right, borrow ripples through r_br.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_br  <= w_bo;
            // Counter holds on the final bit so it only ever wraps via reload.
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == BUSY);
    assign out_valid = (r_state == DONE);
    assign diff      = r_res;
    assign bout      = r_br;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench for serial_subtractor_16bit against an arithmetic reference model.
module tb_serial_subtractor_16bit;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    int n_total = 0;
    int n_bad   = 0;

    serial_subtractor_16bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: unsigned (WIDTH+1)-bit subtraction; MSB is the borrow-out.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = a_i;
        b        = b_i;
        bin      = bin_i;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Inputs are scrambled while waiting: the result must depend only on the accept cycle.
    task automatic wait_done(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i,
                             input string tag);
        int lat;
        logic [W:0] exp;
        exp = ref_sub(a_i, b_i, bin_i);
        lat = 1;
        while (!out_valid && lat < 40) begin
            a   = W'($urandom);
            b   = W'($urandom);
            bin = 1'($urandom);
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd17);
        check({tag, "_diff"}, 32'(diff), 32'(exp[W-1:0]));
        check({tag, "_bout"}, 32'(bout), 32'(exp[W]));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic bin_i,
                          input string tag);
        start_op(a_i, b_i, bin_i);
        wait_done(a_i, b_i, bin_i, tag);
        release_out();
    endtask

    initial begin
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        logic         sbin;
        logic [W-1:0] held_diff;
        logic         held_bout;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;

        run_op(16'h0005, 16'h0003, 1'b0, "basic");
        run_op(16'h0000, 16'h0001, 1'b0, "underflow");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, "all_ones_bin");
        run_op(16'h1234, 16'h1234, 1'b0, "equal");

        // Stall in DONE with in_valid asserted: outputs hold, nothing new accepted.
        start_op(16'hABCD, 16'h1234, 1'b1);
        wait_done(16'hABCD, 16'h1234, 1'b1, "stall");
        held_diff = diff;
        held_bout = bout;
        in_valid  = 1'b1;
        a         = 16'h0F0F;
        b         = 16'h0001;
        bin       = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_diff", 32'(diff), 32'(16'h9998));
            check("stall_bout", 32'(bout), 32'(1'b0));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        check("stall_hold_match", 32'({held_bout, held_diff}), 32'({bout, diff}));
        in_valid = 1'b0;
        release_out();
        check("post_release_out_valid", 32'(out_valid), 32'd0);
        run_op(16'h0F0F, 16'h0001, 1'b0, "after_stall");

        // Asynchronous reset in the middle of BUSY discards the operation.
        start_op(16'h5555, 16'h2222, 1'b0);
        repeat (7) tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_diff", 32'(diff), 32'd0);
        check("arst_bout", 32'(bout), 32'd0);
        tick();
        rst_n = 1'b1;
        run_op(16'h8000, 16'h0001, 1'b0, "after_reset");

        // Sweep: a steps every two ops, b every op, bin toggles.
        sa   = W'($urandom);
        sb   = W'($urandom);
        sbin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            run_op(sa, sb, sbin, "sweep");
            if (i[0]) sa = sa + W'(1);
            sb   = sb + W'(1);
            sbin = ~sbin;
        end

        for (int i = 0; i < 40; i++) begin
            sa   = W'($urandom);
            sb   = W'($urandom);
            sbin = 1'($urandom);
            run_op(sa, sb, sbin, "random");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
